// File: rtl/text_buffer_pkg.sv
// Shared constants and types for the character-cell frame store.
// Holds ASCII control codes, cell geometry and the sweep FSM state type.
package text_pkg;

   localparam logic [6:0] CH_SPACE = 7'h20;
   localparam logic [6:0] CH_BS    = 7'h08;
   localparam logic [6:0] CH_CR    = 7'h0D;
   localparam logic [6:0] CH_FF    = 7'h0C;

   localparam int CELL_SHIFT = 4;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } tb_state_t;

   function automatic logic is_printable(input logic [6:0] c);
      return (c >= 7'h20) && (c <= 7'h7E);
   endfunction

endpackage

// File: rtl/text_buffer_if.sv
// Valid/ready character stream into the frame store.
// master: producer drives i_char/i_char_valid; slave: store drives o_char_ready.
interface text_buffer_if;

   logic [6:0] i_char;
   logic       i_char_valid;
   logic       o_char_ready;

   modport master (
      output i_char,
      output i_char_valid,
      input  o_char_ready
   );

   modport slave (
      input  i_char,
      input  i_char_valid,
      output o_char_ready
   );

endinterface

// File: rtl/text_buffer_ram.sv
// Simple dual-port cell RAM: one synchronous write, one read-first read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (registered read).
module text_ram #(
   parameter int DEPTH = 1200,
   parameter int AW    = 11,
   parameter int DW    = 7
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Both ports update with non-blocking writes, so a same-cycle
   // read of the written cell returns the previous contents.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/text_buffer.sv
// Character-cell frame store: cursor-driven writes, raster-driven reads.
// Ports: pix_clk, rst_n, i_x/i_y raster in, char_if stream, o_x/o_y/character
// raster out (1-cycle), o_cursor_col/o_cursor_row, o_busy (clear sweep).
module text_buffer
   import text_pkg::*;
#(
   parameter  int COLS = 40,
   parameter  int ROWS = 30,
   localparam int CW   = $clog2(COLS),
   localparam int RW   = $clog2(ROWS)
) (
   input  logic          pix_clk,
   input  logic          rst_n,
   input  logic [11:0]   i_x,
   input  logic [11:0]   i_y,
   text_buffer_if.slave  char_if,
   output logic [11:0]   o_x,
   output logic [11:0]   o_y,
   output logic [6:0]    character,
   output logic [CW-1:0] o_cursor_col,
   output logic [RW-1:0] o_cursor_row,
   output logic          o_busy
);

   localparam int CELLS = COLS * ROWS;
   localparam int AW    = $clog2(CELLS);

   tb_state_t     state;
   logic [AW-1:0] sweep;
   logic [CW-1:0] cur_col, col_n;
   logic [RW-1:0] cur_row, row_n;
   logic          ready_q;
   logic          busy_q;

   logic          we;
   logic [AW-1:0] waddr;
   logic [6:0]    wdata;
   logic          go_clear;
   logic          accept;
   logic          col_last, row_last;

   logic [7:0]    col_r, row_r;
   logic          oor;
   logic [AW-1:0] raddr;
   logic [6:0]    rdata;
   logic          blank_q;

   function automatic logic [AW-1:0] cell_addr(
      input logic [RW-1:0] r,
      input logic [CW-1:0] c
   );
      return AW'(r) * AW'(COLS) + AW'(c);
   endfunction

   assign accept   = ready_q && char_if.i_char_valid;
   assign col_last = (cur_col == CW'(COLS - 1));
   assign row_last = (cur_row == RW'(ROWS - 1));

   always_comb begin
      col_n    = cur_col;
      row_n    = cur_row;
      we       = 1'b0;
      waddr    = sweep;
      wdata    = CH_SPACE;
      go_clear = 1'b0;
      if (state == CLEAR) begin
         we = 1'b1;
      end else if (accept) begin
         unique case (1'b1)
            is_printable(char_if.i_char): begin
               we    = 1'b1;
               waddr = cell_addr(cur_row, cur_col);
               wdata = char_if.i_char;
               if (col_last) begin
                  col_n = '0;
                  row_n = row_last ? '0 : cur_row + 1'b1;
               end else begin
                  col_n = cur_col + 1'b1;
               end
            end
            (char_if.i_char == CH_BS): begin
               if (cur_col != '0) begin
                  col_n = cur_col - 1'b1;
                  we    = 1'b1;
               end else if (cur_row != '0) begin
                  col_n = CW'(COLS - 1);
                  row_n = cur_row - 1'b1;
                  we    = 1'b1;
               end
               waddr = cell_addr(row_n, col_n);
            end
            (char_if.i_char == CH_CR): begin
               col_n = '0;
               row_n = row_last ? '0 : cur_row + 1'b1;
            end
            (char_if.i_char == CH_FF): begin
               col_n    = '0;
               row_n    = '0;
               go_clear = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= CLEAR;
         sweep   <= '0;
         cur_col <= '0;
         cur_row <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         cur_col <= col_n;
         cur_row <= row_n;
         unique case (state)
            CLEAR: begin
               if (sweep == AW'(CELLS - 1)) begin
                  state   <= IDLE;
                  sweep   <= '0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  sweep <= sweep + 1'b1;
               end
            end
            IDLE: begin
               if (go_clear) begin
                  state   <= CLEAR;
                  sweep   <= '0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
         endcase
      end
   end

   // Raster read: cell index from the upper coordinate bits; anything
   // outside the grid (or read while sweeping) shows as a blank.
   assign col_r = i_x[11:CELL_SHIFT];
   assign row_r = i_y[11:CELL_SHIFT];
   assign oor   = (32'(col_r) >= COLS) || (32'(row_r) >= ROWS);
   assign raddr = oor ? '0 : AW'(row_r) * AW'(COLS) + AW'(col_r);

   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         o_x     <= '0;
         o_y     <= '0;
         blank_q <= 1'b1;
      end else begin
         o_x     <= i_x;
         o_y     <= i_y;
         blank_q <= oor || (state == CLEAR);
      end
   end

   text_ram #(
      .DEPTH (CELLS),
      .AW    (AW),
      .DW    (7)
   ) u_ram (
      .clk   (pix_clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr),
      .rdata (rdata)
   );

   assign character            = blank_q ? CH_SPACE : rdata;
   assign char_if.o_char_ready = ready_q;
   assign o_cursor_col         = cur_col;
   assign o_cursor_row         = cur_row;
   assign o_busy               = busy_q;

endmodule
